// File: rtl/argmax_pkg.sv
// Shared types and defaults for the argmax sequencer.
// Holds the FSM state enum and the index-width sizing check.
package argmax_pkg;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // True when IDX_W bits can address every class index.
  function automatic bit idx_w_ok(int idx_w, int num_classes);
    return (64'(1) << idx_w) >= 64'(num_classes);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Registered running-max stage for the argmax sequencer.
// Strict greater-than update, so ties keep the lowest index.
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              update_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] best,
  output logic [IDX_W-1:0]  best_idx
);

  logic take;

  // clear marks the first beat of a run: it loads regardless of the old best.
  always_comb begin
    take = update_en && (clear || (in_data > best));
  end

  // Running maximum and the index that produced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best     <= '0;
      best_idx <= '0;
    end else if (take) begin
      best     <= in_data;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/argmax_sequencer.sv
// Serial argmax over NUM_CLASSES score beats.
// Three-state FSM shares one compare/update stage across beats.
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDX_W       = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  max_val,
  output logic [DATA_W-1:0] max_score,
  output logic              busy
);

  if (!idx_w_ok(IDX_W, NUM_CLASSES)) begin : g_idx_w_check
    $error("IDX_W too narrow for NUM_CLASSES");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] count;
  logic             accept;
  logic             first;

  // Abort masks acceptance even though in_ready is state-decoded.
  always_comb begin
    accept = in_valid && in_ready && !abort;
    first  = (count == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; abort has priority over every other event.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nx = COLLECT;
        COLLECT: if (accept && count == LAST) state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Handshake outputs come from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    ;
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Beat counter: cleared on abort or a new start, bumped per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (state == IDLE && start) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
    end
  end

  argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (first),
    .update_en (accept),
    .in_data   (in_data),
    .idx       (count),
    .best      (max_score),
    .best_idx  (max_val)
  );

endmodule
